// File: rtl/arith_pkg.sv
// Shared types and sizing helpers for the digit-serial arithmetic blocks.
// Holds the sequencer state type and the digit-count/counter-width helpers.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int cnt_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational ripple adder for one DIGIT-bit slice.
// Carry in and carry out let the caller chain slices over time.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] sum,
    output logic             co
);

    always_comb begin : ripple
        logic c;
        c   = ci;
        sum = '0;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit x + y + cin, DIGIT bits per cycle,
// with valid/ready handshakes on both the operand and result sides.
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
    end

    localparam int N  = num_digits(WIDTH, DIGIT);
    localparam int CW = cnt_bits(N);

    state_e state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic carry_q, carry_d;
    logic xmsb_q, xmsb_d;
    logic ymsb_q, ymsb_d;
    logic cout_q, cout_d;
    logic ovf_q, ovf_d;

    logic [DIGIT-1:0] dsum;
    logic dco;
    logic load;
    logic [WIDTH-1:0] acc_next;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a  (x_q[DIGIT-1:0]),
        .b  (y_q[DIGIT-1:0]),
        .ci (carry_q),
        .sum(dsum),
        .co (dco)
    );

    // New sum digit enters at the MSB end so the LSB digit lands at bit 0.
    assign acc_next = (acc_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        acc_d     = acc_q;
        s_d       = s_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        xmsb_d    = xmsb_q;
        ymsb_d    = ymsb_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                load     = in_valid;
            end
            ST_BUSY: begin
                x_d     = x_q >> DIGIT;
                y_d     = y_q >> DIGIT;
                carry_d = dco;
                acc_d   = acc_next;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = ST_DONE;
                    s_d     = acc_next;
                    cout_d  = dco;
                    ovf_d   = (xmsb_q == ymsb_q) && (acc_next[WIDTH-1] != xmsb_q);
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready = 1'b1;
                    load     = in_valid;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            state_d = ST_BUSY;
            x_d     = x;
            y_d     = y;
            carry_d = cin;
            xmsb_d  = x[WIDTH-1];
            ymsb_d  = y[WIDTH-1];
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            xmsb_q  <= 1'b0;
            ymsb_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            xmsb_q  <= xmsb_d;
            ymsb_q  <= ymsb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases plus random
// operands against a plain-arithmetic reference, across several geometries.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic in_valid, in_ready, out_valid, out_ready, cin, cout, ovf;
    logic [7:0] x, y, s;

    serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf)
    );

    logic wvalid, wready, wcin;
    logic [31:0] wx, wy;
    logic w8_ir, w8_ov, w8_co, w8_of;
    logic [7:0] w8_s;
    logic w1_ir, w1_ov, w1_co, w1_of;
    logic [31:0] w1_s;
    logic w4_ir, w4_ov, w4_co, w4_of;
    logic [31:0] w4_s;
    logic w32_ir, w32_ov, w32_co, w32_of;
    logic [31:0] w32_s;

    serial_adder #(.WIDTH(8), .DIGIT(8)) u_w8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(wvalid), .in_ready(w8_ir),
        .x(wx[7:0]), .y(wy[7:0]), .cin(wcin),
        .out_valid(w8_ov), .out_ready(wready),
        .s(w8_s), .cout(w8_co), .ovf(w8_of)
    );

    serial_adder #(.WIDTH(32), .DIGIT(1)) u_w1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(wvalid), .in_ready(w1_ir),
        .x(wx), .y(wy), .cin(wcin),
        .out_valid(w1_ov), .out_ready(wready),
        .s(w1_s), .cout(w1_co), .ovf(w1_of)
    );

    serial_adder #(.WIDTH(32), .DIGIT(4)) u_w4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(wvalid), .in_ready(w4_ir),
        .x(wx), .y(wy), .cin(wcin),
        .out_valid(w4_ov), .out_ready(wready),
        .s(w4_s), .cout(w4_co), .ovf(w4_of)
    );

    serial_adder #(.WIDTH(32), .DIGIT(32)) u_w32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(wvalid), .in_ready(w32_ir),
        .x(wx), .y(wy), .cin(wcin),
        .out_valid(w32_ov), .out_ready(wready),
        .s(w32_s), .cout(w32_co), .ovf(w32_of)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum} for a w-bit add.
    function automatic logic [33:0] ref_add(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic c);
        longint unsigned m, t;
        logic [31:0] sm;
        logic co, of;
        m  = (64'd1 << w) - 64'd1;
        t  = (64'(a) & m) + (64'(b) & m) + 64'(c);
        sm = t[31:0] & m[31:0];
        co = t[w];
        of = (a[w-1] == b[w-1]) && (sm[w-1] != a[w-1]);
        return {of, co, sm};
    endfunction

    // Leaves the DUT holding the result; latency counts the accepting edge as 1.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic c, input string tag);
        int k, lat;
        bit seen;
        logic [33:0] r;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk({tag, "_rdy_timeout"}, in_ready, 1);
        x = a; y = b; cin = c; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x = 8'($urandom);
        y = 8'($urandom);
        cin = 1'($urandom);
        lat = 1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) chk({tag, "_busy_ir"}, in_ready, 0);
            if (out_valid) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        r = ref_add(8, {24'b0, a}, {24'b0, b}, c);
        chk({tag, "_lat"}, seen ? lat : 0, 5);
        chk({tag, "_s"}, s, r[7:0]);
        chk({tag, "_co_of"}, {cout, ovf}, {r[32], r[33]});
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_wide(input logic [31:0] a, input logic [31:0] b,
                            input logic c, input string tag);
        bit [3:0] done;
        int lat;
        logic [33:0] r8, r32;
        r8  = ref_add(8, {24'b0, a[7:0]}, {24'b0, b[7:0]}, c);
        r32 = ref_add(32, a, b, c);
        @(negedge clk);
        chk({tag, "_rdy"}, {w8_ir, w1_ir, w4_ir, w32_ir}, 4'hF);
        wx = a; wy = b; wcin = c; wvalid = 1'b1;
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        done = '0;
        lat = 1;
        for (int i = 0; i < 40 && done != 4'hF; i++) begin
            @(negedge clk);
            if (!done[0] && w8_ov) begin
                chk({tag, "_w8"}, {w8_of, w8_co, w8_s}, {r8[33], r8[32], r8[7:0]});
                chk({tag, "_w8_lat"}, lat, 2);
                done[0] = 1'b1;
            end
            if (!done[1] && w1_ov) begin
                chk({tag, "_w1"}, {w1_of, w1_co, w1_s}, r32);
                chk({tag, "_w1_lat"}, lat, 33);
                done[1] = 1'b1;
            end
            if (!done[2] && w4_ov) begin
                chk({tag, "_w4"}, {w4_of, w4_co, w4_s}, r32);
                chk({tag, "_w4_lat"}, lat, 9);
                done[2] = 1'b1;
            end
            if (!done[3] && w32_ov) begin
                chk({tag, "_w32"}, {w32_of, w32_co, w32_s}, r32);
                chk({tag, "_w32_lat"}, lat, 2);
                done[3] = 1'b1;
            end
            @(posedge clk);
            lat++;
        end
        chk({tag, "_done"}, done, 4'hF);
    endtask

    logic [33:0] rh;
    logic [33:0] q[$];
    logic [33:0] e;
    logic [7:0] ox[4], oy[4];
    logic oc[4];
    int sent, got, last_c, cyc, ov_seen;
    bit acc;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; cin = 1'b0;
        wvalid = 1'b0; wready = 1'b1;
        wx = '0; wy = '0; wcin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hold", {out_valid, cout, ovf, s}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ir", in_ready, 1);
        chk("rst_out", {out_valid, cout, ovf, s}, 0);

        run_op(8'hFF, 8'h01, 1'b0, "wrap");
        consume();
        run_op(8'h80, 8'h80, 1'b1, "neg_ovf");
        consume();

        // Result held while the consumer stalls; operand pulses must be ignored.
        run_op(8'h7F, 8'h01, 1'b0, "pos_ovf");
        rh = ref_add(8, 32'h7F, 32'h01, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            x = 8'($urandom);
            y = 8'($urandom);
            chk("hold", {out_valid, in_ready, rh[32], rh[33], s},
                {1'b1, 1'b0, cout, ovf, rh[7:0]});
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume();
        @(negedge clk);
        chk("idle_hold", {out_valid, in_ready, cout, ovf, s},
            {1'b0, 1'b1, rh[32], rh[33], rh[7:0]});

        for (int i = 0; i < 6; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), "rand8");
            consume();
        end

        // Back-to-back: both handshakes held high.
        for (int i = 0; i < 4; i++) begin
            ox[i] = 8'($urandom);
            oy[i] = 8'($urandom);
            oc[i] = 1'($urandom);
        end
        sent = 0; got = 0; last_c = -1; cyc = 0;
        @(negedge clk);
        x = ox[0]; y = oy[0]; cin = oc[0];
        in_valid = 1'b1; out_ready = 1'b1;
        while (got < 4 && cyc < 60) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("b2b_extra", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("b2b_s", s, e[7:0]);
                    chk("b2b_co_of", {cout, ovf}, {e[32], e[33]});
                    if (last_c >= 0) chk("b2b_gap", cyc - last_c, 5);
                end
                last_c = cyc;
                got++;
            end
            acc = in_valid && in_ready;
            if (acc) q.push_back(ref_add(8, {24'b0, x}, {24'b0, y}, cin));
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                if (sent < 4) begin
                    x = ox[sent]; y = oy[sent]; cin = oc[sent];
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        chk("b2b_count", got, 4);
        out_ready = 1'b0;

        // Reset during the second BUSY cycle discards the operation.
        @(negedge clk);
        x = 8'h55; y = 8'hAA; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out", {out_valid, cout, ovf, s}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        chk("midrst_noout", ov_seen, 0);
        chk("midrst_ir", in_ready, 1);
        run_op(8'h01, 8'h02, 1'b0, "post_rst");
        consume();

        run_wide(32'h0000_00F0, 32'h0000_000F, 1'b1, "wdir");
        run_wide(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "wcarry");
        for (int i = 0; i < 8; i++) begin
            run_wide($urandom, $urandom, 1'($urandom), "wrand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
